i_fab_arb: RTL and testbench
============================

I_FAB_ARB -- requirements
Module: i_fab_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the fabric input path (legal range 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 1, width of each requester's fabric input lane.
REQ-003 SHALL have parameter MAX_HOLD, default 16, maximum grant length in cycles when the timeout is compiled in (legal range 2..255).
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port REQ  input  NUM_REQ  per-requester request, level-held for the whole transfer.
REQ-007 SHALL have port I  input  NUM_REQ*DATA_WIDTH  requester data; lane r is I[r*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port GNT  output  NUM_REQ  one-hot grant, registered.
REQ-009 SHALL have port O  output  DATA_WIDTH  registered data of the granted lane.
REQ-010 SHALL have port O_VALID  output  1  high when O carries granted data.
REQ-011 SHALL have port BUSY  output  1  high while any grant is held.
REQ-012 SHALL have port TIMEOUT  output  1  one-cycle pulse on forced grant revocation.

Function
REQ-013 SHALL implement two states: IDLE and GRANT.
REQ-014 In IDLE, at an edge with any eligible REQ bit high, SHALL select the first eligible requester after LAST, the last-granted index, in ascending modulo-NUM_REQ order, set GNT to that requester's one-hot code, update LAST and enter GRANT.
REQ-015 Grant latency SHALL be exactly one edge: a REQ bit sampled high at edge k in IDLE gives GNT high after edge k.
REQ-016 In GRANT, at each edge, SHALL load O from the granted lane and load O_VALID from the GNT value held before that edge; O_VALID therefore lags GNT by one cycle on both rising and falling transitions.
REQ-017 In GRANT, a granted REQ bit sampled low at edge m SHALL clear GNT after edge m and return the block to IDLE.
REQ-018 At edge m, O SHALL still capture the granted lane.
REQ-019 O_VALID SHALL fall after edge m+1, and O SHALL hold its last value while O_VALID is low.
REQ-020 Every grant SHALL be followed by at least one IDLE cycle, so back-to-back grants are separated by exactly one cycle of GNT equal to 0.
REQ-021 REQ changes of non-granted requesters during GRANT SHALL NOT affect GNT, O or O_VALID.
REQ-022 GNT SHALL never have more than one bit set, and BUSY SHALL equal the OR of the GNT bits.
REQ-023 When all REQ bits are high, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0, and no requester SHALL wait more than NUM_REQ-1 grants.

Reset
REQ-024 While RST is high, regardless of CLK, SHALL hold state=IDLE, GNT=0, O=0, O_VALID=0, BUSY=0, TIMEOUT=0, hold counter=0, eligibility mask=all eligible, and LAST=NUM_REQ-1 so that requester 0 wins first.
REQ-025 Assertion of RST mid-grant SHALL clear GNT and O_VALID immediately, without waiting for a clock edge.
REQ-026 The first arbitration SHALL occur at the first CLK edge after RST is released.

Configuration
REQ-027 With macro I_FAB_ARB_TIMEOUT_EN defined, a hold counter SHALL clear on grant and increment at each edge in GRANT.
REQ-028 With I_FAB_ARB_TIMEOUT_EN defined, at the edge where the counter reaches MAX_HOLD and REQ is still high, the block SHALL clear GNT, pulse TIMEOUT high for one cycle and return to IDLE.
REQ-029 With I_FAB_ARB_TIMEOUT_EN defined, a revoked requester SHALL be ineligible until its REQ bit is sampled low, then eligible again.
REQ-030 With I_FAB_ARB_TIMEOUT_EN defined, release and timeout at the same edge SHALL be treated as release, with no TIMEOUT pulse.
REQ-031 Without I_FAB_ARB_TIMEOUT_EN, TIMEOUT SHALL be tied to 0, grant length SHALL be unbounded, and no counter or mask logic SHALL be built.

Verification
REQ-032 SHALL cover: NUM_REQ=4, REQ=4'b0100 held 5 cycles, I lane2=1 -> GNT=4'b0100 one edge after the request, O_VALID high from the next edge, O=1, GNT=0 one edge after REQ falls.
REQ-033 SHALL cover: REQ=4'b1111 held constant, each requester dropping REQ after 3 grant cycles and re-raising it -> grant order 0,1,2,3,0 with exactly one GNT=0 cycle between grants.
REQ-034 SHALL cover: 64 cycles of random lane data under a single grant -> O equals the granted lane delayed one cycle in every O_VALID cycle (zero mismatches), and O_VALID stays low while GNT=0.
REQ-035 SHALL cover: RST asserted between clock edges during a grant -> GNT, O_VALID and O go to 0 before the next CLK edge, and requester 0 wins first after RST is released.
REQ-036 SHALL cover: I_FAB_ARB_TIMEOUT_EN defined, MAX_HOLD=4, REQ[1] held 10 cycles with REQ[3] high -> GNT[1] revoked after 4 grant edges, TIMEOUT pulses once, GNT[3] follows, and requester 1 is not regranted until REQ[1] toggles.
REQ-037 SHALL cover: REQ=4'b0000 for 20 cycles -> GNT, O_VALID, BUSY and TIMEOUT all stay 0.

Source files
------------

// File: rtl/i_fab_arb.sv
// i_fab_arb: round-robin arbiter for a shared fabric input path.
//
// Each requester holds its REQ bit high for the whole transfer. In IDLE the
// block grants the first eligible requester after the last-granted index
// (ascending, modulo NUM_REQ). While a grant is held it registers the granted
// lane onto O; O_VALID trails GNT by one cycle. A release always costs one
// IDLE cycle before the next grant.
//
// Optional feature (macro I_FAB_ARB_TIMEOUT_EN): a hold counter bounds each
// grant to MAX_HOLD cycles. A revoked requester pulses TIMEOUT and stays
// ineligible until its REQ bit is sampled low. Without the macro TIMEOUT is
// tied low and no counter or eligibility mask exists.
//
// Parameters:
//   NUM_REQ    number of requesters (2..8)
//   DATA_WIDTH width of each requester lane
//   MAX_HOLD   maximum grant length in cycles with the timeout built in (2..255)
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   REQ      in   [NUM_REQ]            per-requester level request
//   I        in   [NUM_REQ*DATA_WIDTH] requester lanes, lane r at r*DATA_WIDTH
//   GNT      out  [NUM_REQ]            one-hot registered grant
//   O        out  [DATA_WIDTH]         registered data of the granted lane
//   O_VALID  out  O carries granted data (GNT delayed by one cycle)
//   BUSY     out  a grant is held (OR of GNT)
//   TIMEOUT  out  one-cycle pulse on forced revocation
module i_fab_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] I,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [DATA_WIDTH-1:0]         O,
    output logic                          O_VALID,
    output logic                          BUSY,
    output logic                          TIMEOUT
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]   LAST_RST = IDX_W'(NUM_REQ - 32'sd1);
    localparam logic [NUM_REQ-1:0] GNT_ZERO = {NUM_REQ{1'b0}};
    localparam logic [NUM_REQ-1:0] GNT_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Out-of-range parameters leave a named marker block in the elaborated tree.
    if ((NUM_REQ < 32'sd2) || (NUM_REQ > 32'sd8)) begin : g_num_req_illegal
    end
    if ((MAX_HOLD < 32'sd2) || (MAX_HOLD > 32'sd255)) begin : g_max_hold_illegal
    end

    state_t                  state_r, state_nxt_s;
    logic [NUM_REQ-1:0]      gnt_r, gnt_nxt_s;
    logic [IDX_W-1:0]        last_r, last_nxt_s;
    logic [DATA_WIDTH-1:0]   o_r, o_nxt_s;
    logic                    o_valid_r, o_valid_nxt_s;
    logic                    busy_r;
    logic [NUM_REQ-1:0]      elig_s;
    logic                    found_s;
    logic [IDX_W-1:0]        sel_s;
    logic [IDX_W-1:0]        cand_s;
    logic [DATA_WIDTH-1:0]   lane_s;

`ifdef I_FAB_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 32'sd1);

    logic [7:0]              cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0]      mask_r, mask_nxt_s;
    logic                    timeout_r, timeout_nxt_s;

    // A revoked requester is masked out until it drops its request.
    always_comb begin
        elig_s = REQ & mask_r;
    end
`else
    // Every requester is always eligible when the timeout is not built.
    always_comb begin
        elig_s = REQ;
    end
`endif

    // Round-robin search: first eligible index after last_r, wrapping.
    always_comb begin
        found_s = 1'b0;
        sel_s   = last_r;
        cand_s  = last_r;
        for (int k = 32'sd1; k <= NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(last_r) + k) % NUM_REQ);
            if (!found_s && elig_s[cand_s]) begin
                found_s = 1'b1;
                sel_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // While granted, last_r is the owner, so it also selects the data lane.
    always_comb begin
        lane_s = I[int'(last_r) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state and output logic for the IDLE/GRANT controller.
    always_comb begin
        state_nxt_s   = state_r;
        gnt_nxt_s     = gnt_r;
        last_nxt_s    = last_r;
        o_nxt_s       = o_r;
        o_valid_nxt_s = |gnt_r;
`ifdef I_FAB_ARB_TIMEOUT_EN
        cnt_nxt_s     = cnt_r;
        mask_nxt_s    = mask_r | ~REQ;
        timeout_nxt_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_nxt_s   = GNT_ONE << sel_s;
                    last_nxt_s  = sel_s;
                    state_nxt_s = ST_GRANT;
`ifdef I_FAB_ARB_TIMEOUT_EN
                    cnt_nxt_s   = 8'd0;
`endif
                end else begin
                    gnt_nxt_s = GNT_ZERO;
                end
            end
            ST_GRANT: begin
                // O captures the lane even on the release edge.
                o_nxt_s = lane_s;
                if (!REQ[last_r]) begin
                    gnt_nxt_s   = GNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end
`ifdef I_FAB_ARB_TIMEOUT_EN
                else if (cnt_r == HOLD_LAST) begin
                    // Release wins over timeout because it is tested first.
                    gnt_nxt_s          = GNT_ZERO;
                    state_nxt_s        = ST_IDLE;
                    timeout_nxt_s      = 1'b1;
                    mask_nxt_s[last_r] = 1'b0;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
`else
                else begin
                    gnt_nxt_s = gnt_r;
                end
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = GNT_ZERO;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            gnt_r     <= GNT_ZERO;
            last_r    <= LAST_RST;
            o_r       <= {DATA_WIDTH{1'b0}};
            o_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            last_r    <= last_nxt_s;
            o_r       <= o_nxt_s;
            o_valid_r <= o_valid_nxt_s;
            busy_r    <= |gnt_nxt_s;
        end
    end

`ifdef I_FAB_ARB_TIMEOUT_EN
    // Hold counter, eligibility mask and timeout pulse registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r     <= 8'd0;
            mask_r    <= {NUM_REQ{1'b1}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            mask_r    <= mask_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign TIMEOUT = timeout_r;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign GNT     = gnt_r;
    assign O       = o_r;
    assign O_VALID = o_valid_r;
    assign BUSY    = busy_r;

endmodule

// File: tb/tb_i_fab_arb.sv
// tb_i_fab_arb: randomized scoreboard bench for i_fab_arb.
// A behavioural model predicts the post-edge outputs for every driven cycle
// and queues them; a monitor pops and compares after each rising edge.
module tb_i_fab_arb;

    localparam int N  = 4;
    localparam int DW = 4;
`ifdef I_FAB_ARB_TIMEOUT_EN
    localparam int MH    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MH    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    REQ;
    logic [N*DW-1:0] I;
    logic [N-1:0]    GNT;
    logic [DW-1:0]   O;
    logic            O_VALID;
    logic            BUSY;
    logic            TIMEOUT;

    i_fab_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_HOLD(MH)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .I(I),
        .GNT(GNT), .O(O), .O_VALID(O_VALID), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic          valid;
        logic          busy;
        logic          to;
        logic [DW-1:0] o;
    } exp_t;

    exp_t          ctrl_q[$];
    logic [DW-1:0] data_q[$];
    int            checks   = 0;
    int            failures = 0;

    // Reference model: who owns the path, who was granted last, how long held.
    int            m_owner;
    int            m_last;
    int            m_hold;
    bit [N-1:0]    m_blocked;
    logic [DW-1:0] m_o;

    // Rotation tracking (monitor side)
    bit            track = 1'b0;
    int            order_q[$];
    int            gaps_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_hold    = 0;
        m_blocked = '0;
        m_o       = '0;
        ctrl_q.delete();
        data_q.delete();
    endtask

    // Predict the outputs after the next rising edge given the sampled inputs.
    task automatic model_step(input logic [N-1:0] req, input logic [N*DW-1:0] data);
        int   prev;
        int   c;
        bit   to;
        exp_t e;
        prev = m_owner;
        to   = 1'b0;
        if (prev >= 0) begin
            m_o = data[prev*DW +: DW];
            data_q.push_back(m_o);
            if (!req[prev]) begin
                m_owner = -1;
            end else if (TO_EN && (m_hold + 1 == MH)) begin
                m_blocked[prev] = 1'b1;
                to      = 1'b1;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (req[c] && !m_blocked[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_hold  = 0;
                    break;
                end
            end
        end
        m_blocked = m_blocked & req;
        e.gnt   = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        e.valid = (prev >= 0);
        e.busy  = (m_owner >= 0);
        e.to    = to;
        e.o     = m_o;
        ctrl_q.push_back(e);
    endtask

    task automatic apply(input logic [N-1:0] req, input logic [N*DW-1:0] data);
        REQ = req;
        I   = data;
        model_step(req, data);
    endtask

    task automatic step(input logic [N-1:0] req, input logic [N*DW-1:0] data);
        @(negedge CLK);
        apply(req, data);
    endtask

    function automatic logic [N*DW-1:0] rnd();
        return (N*DW)'($urandom());
    endfunction

    task automatic summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    // Monitor: compare DUT outputs against queued predictions after each edge.
    initial begin
        exp_t          e;
        logic [DW-1:0] d;
        logic [N-1:0]  prev_g;
        int            zero_run;
        int            idx;
        prev_g   = '0;
        zero_run = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (ctrl_q.size() > 0) begin
                e = ctrl_q.pop_front();
                check("gnt", 32'(GNT), 32'(e.gnt));
                check("o_valid", 32'(O_VALID), 32'(e.valid));
                check("busy", 32'(BUSY), 32'(e.busy));
                check("timeout", 32'(TIMEOUT), 32'(e.to));
                if (O_VALID) begin
                    if (data_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL o_data: O_VALID high with no expected data at %0t", $time);
                    end else begin
                        d = data_q.pop_front();
                        check("o_data", 32'(O), 32'(d));
                    end
                end else begin
                    if (e.valid && data_q.size() > 0) begin
                        d = data_q.pop_front();
                    end
                    check("o_hold", 32'(O), 32'(e.o));
                end
            end
            if (track) begin
                if (GNT != '0) begin
                    if (prev_g == '0) begin
                        idx = 0;
                        for (int b = 0; b < N; b++) if (GNT[b]) idx = b;
                        if (order_q.size() > 0) gaps_q.push_back(zero_run);
                        order_q.push_back(idx);
                    end
                    zero_run = 0;
                end else begin
                    zero_run++;
                end
            end
            prev_g = GNT;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        summary();
        $finish;
    end

    // Stimulus
    initial begin
        int           gcyc;
        logic [N-1:0] req;
        logic [N-1:0] cur_req;
        int           exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};

        RST = 1'b1;
        REQ = '0;
        I   = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #2;
        check("rst_gnt", 32'(GNT), 32'd0);
        check("rst_o", 32'(O), 32'd0);
        check("rst_o_valid", 32'(O_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_timeout", 32'(TIMEOUT), 32'd0);

        // Idle: no requests for 20 cycles
        @(negedge CLK);
        RST = 1'b0;
        apply('0, rnd());
        repeat (19) step('0, rnd());

        // Full load: each owner drops after 3 grant cycles and re-raises
        track = 1'b1;
        gcyc  = 0;
        for (int c = 0; c < 22; c++) begin
            req = '1;
            if (m_owner >= 0) begin
                gcyc++;
                if (gcyc == 3) begin
                    req[m_owner] = 1'b0;
                    gcyc = 0;
                end
            end
            step(req, rnd());
        end
        step('0, rnd());
        track = 1'b0;
        check("rot_count", 32'(order_q.size() >= 5), 32'd1);
        if (order_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rot_order", 32'(order_q[i]), 32'(exp_order[i]));
            for (int i = 0; i < 4; i++) check("rot_gap", 32'(gaps_q[i]), 32'd1);
        end
        repeat (3) step('0, rnd());

        // Single requester 2, lane 2 = 1, held 5 cycles
        repeat (5) step(4'b0100, 16'h0100);
        repeat (3) step('0, 16'h0100);

        // 64+ cycles of random data under one grant
        repeat (66) step(4'b0010, rnd());
        repeat (3) step('0, rnd());

        // Random requests with random data
        cur_req = '0;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) cur_req = N'($urandom());
            step(cur_req, rnd());
        end
        repeat (3) step('0, rnd());

        // Long hold on requester 1 with requester 3 waiting, then toggle 1
        step(4'b0010, rnd());
        repeat (9) step(4'b1010, rnd());
        repeat (3) step(4'b1000, rnd());
        repeat (6) step(4'b1010, rnd());
        repeat (3) step('0, rnd());

        // Asynchronous reset in the middle of a grant
        repeat (4) step(4'b0100, 16'h0A00);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        check("arst_gnt", 32'(GNT), 32'd0);
        check("arst_o_valid", 32'(O_VALID), 32'd0);
        check("arst_o", 32'(O), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        model_reset();
        REQ = '1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        apply('1, rnd());
        @(posedge CLK);
        #3;
        check("first_after_rst", 32'(GNT), 32'd1);
        repeat (8) step('1, rnd());
        repeat (3) step('0, rnd());

        @(posedge CLK);
        #3;
        check("ctrl_q_empty", 32'(ctrl_q.size()), 32'd0);
        check("data_q_empty", 32'(data_q.size()), 32'd0);
        summary();
        $finish;
    end

endmodule
